hazard_stall_ctrl: RTL

//  Producer side of the forwarding interface. Tracks the destination/write info of the

---
 rtl/hazard_stall_ctrl_if.sv | 41 ++++
 rtl/hazard_stall_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Forwarding/hazard interface: ID-stage inputs in, forwarding info and pipeline controls out.
interface hazard_stall_ctrl_if #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic             id_wrx;
  logic             id_memrd;
  logic [REG_W-1:0] id_dest;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_use_src2;
  logic             branch_taken;
  logic             mem_ready;
  logic             WrX_s;
  logic             MemRd_s;
  logic [REG_W-1:0] dest_s;
  logic             WrX_s2;
  logic [REG_W-1:0] dest_s2;
  logic             stall_pc;
  logic             bubble_ex;
  logic             freeze;
  logic             flush_id;
  logic             mem_timeout;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mw_cnt;

  modport master (
    input  id_valid, id_wrx, id_memrd, id_dest, id_src1, id_src2, id_use_src2,
    input  branch_taken, mem_ready,
    output WrX_s, MemRd_s, dest_s, WrX_s2, dest_s2,
    output stall_pc, bubble_ex, freeze, flush_id, mem_timeout, lu_cnt, mw_cnt
  );

  modport slave (
    output id_valid, id_wrx, id_memrd, id_dest, id_src1, id_src2, id_use_src2,
    output branch_taken, mem_ready,
    input  WrX_s, MemRd_s, dest_s, WrX_s2, dest_s2,
    input  stall_pc, bubble_ex, freeze, flush_id, mem_timeout, lu_cnt, mw_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Tracks EX/WB destination info for forwarding and resolves load-use, memory-wait and
// taken-branch hazards with zero-cycle combinational control.
module hazard_stall_ctrl #(
  parameter int unsigned REG_W   = 4,
  parameter int unsigned CNT_W   = 16,
  parameter bit          R0_ZERO = 1'b1,
  parameter int unsigned MEM_TMO = 255
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.master bus
);
  localparam int unsigned WC_W = (MEM_TMO > 0) ? $clog2(MEM_TMO + 1) : 1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state, state_nxt;
  logic             ex_v, ex_wrx, ex_memrd;
  logic [REG_W-1:0] ex_dest;
  logic             wb_v, wb_wrx;
  logic [REG_W-1:0] wb_dest;
  logic [WC_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [CNT_W-1:0] lu_cnt, lu_cnt_nxt, mw_cnt, mw_cnt_nxt;

  logic ex_r0, wb_r0, wrx_s, memrd_s, wrx_s2, src_hit, lu, mw;
  logic stall_pc, bubble_ex, freeze, flush_id, mem_timeout;
  logic hold, ex_nop;

  // Forwarding view of the slots; r0 writes are invisible when R0_ZERO is set
  assign ex_r0   = R0_ZERO && (ex_dest == '0);
  assign wb_r0   = R0_ZERO && (wb_dest == '0);
  assign wrx_s   = ex_v & ex_wrx & ~ex_r0;
  assign memrd_s = ex_v & ex_memrd;
  assign wrx_s2  = wb_v & wb_wrx & ~wb_r0;

  assign src_hit = (bus.id_src1 == ex_dest) | (bus.id_use_src2 & (bus.id_src2 == ex_dest));
  assign lu      = memrd_s & bus.id_valid & src_hit & ~ex_r0;
  assign mw      = memrd_s & ~bus.mem_ready;

  // Hazard priority: memory wait, then taken branch, then load-use
  always_comb begin
    state_nxt    = RUN;
    wait_cnt_nxt = wait_cnt;
    lu_cnt_nxt   = lu_cnt;
    mw_cnt_nxt   = mw_cnt;
    stall_pc     = 1'b0;
    bubble_ex    = 1'b0;
    freeze       = 1'b0;
    flush_id     = 1'b0;
    mem_timeout  = 1'b0;
    hold         = 1'b0;
    ex_nop       = 1'b0;
    if (mw) begin
      freeze    = 1'b1;
      stall_pc  = 1'b1;
      hold      = 1'b1;
      state_nxt = MEM_WAIT;
      if (mw_cnt != '1) mw_cnt_nxt = mw_cnt + CNT_W'(1);
      if (state == RUN) begin
        wait_cnt_nxt = '0;
      end else begin
        if (wait_cnt != '1) wait_cnt_nxt = wait_cnt + WC_W'(1);
        mem_timeout = (MEM_TMO != 0) && (wait_cnt == WC_W'(MEM_TMO - 1));
      end
    end else if (bus.branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
      ex_nop    = 1'b1;
    end else if (lu) begin
      stall_pc  = 1'b1;
      bubble_ex = 1'b1;
      ex_nop    = 1'b1;
      if (lu_cnt != '1) lu_cnt_nxt = lu_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      lu_cnt   <= '0;
      mw_cnt   <= '0;
      ex_v     <= 1'b0;
      ex_wrx   <= 1'b0;
      ex_memrd <= 1'b0;
      ex_dest  <= '0;
      wb_v     <= 1'b0;
      wb_wrx   <= 1'b0;
      wb_dest  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      lu_cnt   <= lu_cnt_nxt;
      mw_cnt   <= mw_cnt_nxt;
      if (!hold) begin
        wb_v    <= ex_v;
        wb_wrx  <= ex_wrx;
        wb_dest <= ex_dest;
        if (ex_nop) begin
          ex_v     <= 1'b0;
          ex_wrx   <= 1'b0;
          ex_memrd <= 1'b0;
          ex_dest  <= '0;
        end else begin
          ex_v     <= bus.id_valid;
          ex_wrx   <= bus.id_wrx;
          ex_memrd <= bus.id_memrd;
          ex_dest  <= bus.id_dest;
        end
      end
    end
  end

  assign bus.WrX_s       = wrx_s;
  assign bus.MemRd_s     = memrd_s;
  assign bus.dest_s      = ex_dest;
  assign bus.WrX_s2      = wrx_s2;
  assign bus.dest_s2     = wb_dest;
  assign bus.stall_pc    = stall_pc;
  assign bus.bubble_ex   = bubble_ex;
  assign bus.freeze      = freeze;
  assign bus.flush_id    = flush_id;
  assign bus.mem_timeout = mem_timeout;
  assign bus.lu_cnt      = lu_cnt;
  assign bus.mw_cnt      = mw_cnt;
endmodule
